// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA text-overlay path: character grid geometry,
// char code constants used by the font ROM, and the character-buffer
// controller state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int CHAR_COLS   = 16;
    localparam int CHAR_ROWS   = 16;
    localparam int CHAR_CODE_W = 7;

    typedef logic [CHAR_CODE_W-1:0] char_code_t;

    // Font ROM code points (ASCII-compatible subset)
    localparam char_code_t Spc = 7'h20;
    localparam char_code_t Ch0 = 7'h30;
    localparam char_code_t ChA = 7'h41;
    localparam char_code_t ChG = 7'h47;
    localparam char_code_t ChM = 7'h4D;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_DONE,
        ST_IDLE
    } char_buf_state_t;

    // Code for decimal digit d (0..9)
    function automatic char_code_t digit_code(input logic [3:0] d);
        return Ch0 + char_code_t'(d);
    endfunction

    // Code for the i-th upper-case letter (0 = 'A')
    function automatic char_code_t letter_code(input logic [4:0] i);
        return ChA + char_code_t'(i);
    endfunction

endpackage

// File: rtl/char_buf_ctrl_if.sv
// ----------------------------------------------------------------------------
// char_buf_ctrl_if
// Bundles the character buffer's display read port, the two logic-side
// writer handshakes and the clear controls.
//   master : display pipeline / writers / clear requester
//   slave  : char_buf_ctrl
// Signals:
//   char_xy, char_code                 display read {row,col} -> code
//   wrN_valid/addr/data, wrN_ready     writer N valid/ready handshake
//   clear_req, busy, clear_done        blank-fill request and status
// ----------------------------------------------------------------------------
interface char_buf_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 7
);
    logic [ADDR_W-1:0] char_xy;
    logic [DATA_W-1:0] char_code;

    logic              wr0_valid;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr0_ready;

    logic              wr1_valid;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;
    logic              wr1_ready;

    logic              clear_req;
    logic              busy;
    logic              clear_done;

    modport master (
        output char_xy, wr0_valid, wr0_addr, wr0_data,
               wr1_valid, wr1_addr, wr1_data, clear_req,
        input  char_code, wr0_ready, wr1_ready, busy, clear_done
    );

    modport slave (
        input  char_xy, wr0_valid, wr0_addr, wr0_data,
               wr1_valid, wr1_addr, wr1_data, clear_req,
        output char_code, wr0_ready, wr1_ready, busy, clear_done
    );
endinterface

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with combinational grant. When both requests
// are present the requester that did not win last time is granted.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   req[1:0]     request per requester
//   enable       grants are suppressed when low
//   accept       a grant was taken this cycle; records the winner
//   gnt[1:0]     one-hot (or zero) grant
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       accept,
    output logic [1:0] gnt
);
    // Index of the most recent winner; reset to 1 so requester 0 wins first.
    logic last;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last <= 1'b1;
        else if (accept) last <= gnt[1];
    end

    // NOTE: every output of a combinational block gets a default first,
    // otherwise an uncovered path holds its old value and infers a latch.
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end
endmodule

// File: rtl/char_buf_ctrl.sv
// ----------------------------------------------------------------------------
// char_buf_ctrl
// Writable 16x16 character buffer for the VGA text overlay. The display side
// reads a char code per cell with one cycle of latency; two writers share
// the single write port through a round-robin arbiter; a clear sequencer
// fills every cell with CLEAR_CODE after reset or on clear_req.
// Ports:
//   clk     pixel-domain clock
//   rst_n   asynchronous active-low reset
//   bus     char_buf_ctrl_if.slave (read port, writer handshakes, clear)
// ----------------------------------------------------------------------------
module char_buf_ctrl
    import vga_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 7,
    parameter logic [DATA_W-1:0] CLEAR_CODE = Spc
) (
    input logic           clk,
    input logic           rst_n,
    char_buf_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    char_buf_state_t   state, state_nxt;
    logic [ADDR_W-1:0] cnt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        req, gnt;
    logic              arb_en, accept, we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // ---------------- state register + clear counter ----------------
    // The counter only runs in ST_CLEAR and is parked at 0 elsewhere, so
    // every clear starts from cell 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) cnt <= cnt + ADDR_W'(1);
            else                   cnt <= '0;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_CLEAR: if (cnt == '1) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            ST_IDLE:  if (bus.clear_req) state_nxt = ST_CLEAR;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // ---------------- output logic ----------------
    // A clear request in IDLE wins over the writers in the same cycle.
    always_comb begin
        bus.busy       = 1'b0;
        bus.clear_done = 1'b0;
        arb_en         = 1'b0;
        unique case (state)
            ST_CLEAR: bus.busy       = 1'b1;
            ST_DONE:  bus.clear_done = 1'b1;
            ST_IDLE:  arb_en         = !bus.clear_req;
            default:  bus.busy       = 1'b1;
        endcase
    end

    // ---------------- writer arbitration ----------------
    assign req    = {bus.wr1_valid, bus.wr0_valid};
    assign accept = |(gnt & req);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .enable (arb_en),
        .accept (accept),
        .gnt    (gnt)
    );

    assign bus.wr0_ready = gnt[0];
    assign bus.wr1_ready = gnt[1];

    // ---------------- write port ----------------
    assign we = (state == ST_CLEAR) || accept;

    always_comb begin
        waddr = cnt;
        wdata = CLEAR_CODE;
        if (state != ST_CLEAR) begin
            waddr = gnt[1] ? bus.wr1_addr : bus.wr0_addr;
            wdata = gnt[1] ? bus.wr1_data : bus.wr0_data;
        end
    end

    // NOTE: the storage array has no reset; a reset branch would prevent
    // RAM inference, and the clear sequence initialises it instead.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read and write of the same cell in one cycle return the old contents,
    // since both sample the array before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.char_code <= '0;
        else        bus.char_code <= mem[bus.char_xy];
    end
endmodule

// File: tb/tb_char_buf_ctrl.sv
// ----------------------------------------------------------------------------
// tb_char_buf_ctrl
// Self-checking bench for char_buf_ctrl. Stimulus predicts each cycle's
// grant and read data from a cell-array model and pushes them onto queues;
// a monitor on the falling edge pops and compares whenever a ready is seen
// or a read result is due.
// ----------------------------------------------------------------------------
module tb_char_buf_ctrl;
    import vga_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 7;
    localparam int DEPTH  = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    char_buf_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    char_buf_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .CLEAR_CODE (Spc)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cell contents, last winner, whether the buffer is idle.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_last = 1;
    bit                m_idle = 1'b0;

    int                gnt_q[$];
    logic [DATA_W-1:0] rd_q[$];
    logic              rd_issue = 1'b0;
    logic              rd_vld   = 1'b0;
    int                mon_g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) rd_vld <= rd_issue;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr0_ready || bus.wr1_ready) begin
                if (gnt_q.size() == 0) begin
                    check("unexpected_ready", {30'b0, bus.wr1_ready, bus.wr0_ready}, 32'd0);
                end else begin
                    mon_g = gnt_q.pop_front();
                    check("grant", {30'b0, bus.wr1_ready, bus.wr0_ready},
                          (mon_g == 0) ? 32'd1 : 32'd2);
                end
            end
            if (rd_vld) begin
                if (rd_q.size() == 0) check("read_expected", rd_q.size(), 32'd1);
                else                  check("char_code", 32'(bus.char_code), 32'(rd_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // One cycle of stimulus; g returns the predicted winner (-1 for none).
    task automatic drive(input logic v0, input logic [7:0] a0, input logic [6:0] d0,
                         input logic v1, input logic [7:0] a1, input logic [6:0] d1,
                         input logic rd, input logic [7:0] xy, input logic creq,
                         output int g);
        @(posedge clk);
        #1;
        bus.wr0_valid = v0; bus.wr0_addr = a0; bus.wr0_data = d0;
        bus.wr1_valid = v1; bus.wr1_addr = a1; bus.wr1_data = d1;
        bus.char_xy   = xy;
        bus.clear_req = creq;
        rd_issue      = rd;
        // The read sees the contents before this cycle's write lands.
        if (rd) rd_q.push_back(m_mem[xy]);
        g = -1;
        if (m_idle && !creq) begin
            if (v0 && v1)  g = (m_last == 0) ? 1 : 0;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
        end
        if (g >= 0) begin
            gnt_q.push_back(g);
            if (g == 0) m_mem[a0] = d0;
            else        m_mem[a1] = d1;
            m_last = g;
        end
        if (m_idle && creq) m_idle = 1'b0;
    endtask

    task automatic read_cell(input logic [7:0] xy);
        int g;
        drive(1'b0, 8'h00, 7'h00, 1'b0, 8'h00, 7'h00, 1'b1, xy, 1'b0, g);
    endtask

    task automatic idle_cycle();
        int g;
        drive(1'b0, 8'h00, 7'h00, 1'b0, 8'h00, 7'h00, 1'b0, 8'h00, 1'b0, g);
    endtask

    // Counts rising edges until clear_done is seen; busy must stay high
    // until then and clear_done must last exactly one cycle.
    task automatic wait_clear(input string name, input int exp_edges);
        int n = 0;
        bit seen = 1'b0;
        int busy_bad = 0;
        rd_issue = 1'b0;
        while (!seen && n < 400) begin
            @(posedge clk);
            n++;
            if (n == 1) begin
                #1;
                bus.clear_req = 1'b0;
                bus.wr0_valid = 1'b0;
                bus.wr1_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.clear_done === 1'b1) seen = 1'b1;
            else if (bus.busy !== 1'b1) busy_bad++;
        end
        check({name, "_done_edge"}, n, exp_edges);
        check({name, "_busy_during"}, busy_bad, 32'd0);
        check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        check({name, "_done_single"}, 32'(bus.clear_done), 32'd0);
        for (int i = 0; i < DEPTH; i++) m_mem[i] = Spc;
        m_idle = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int g;
        bit p0, p1;
        logic [7:0] a0, a1;
        logic [6:0] d0, d1;

        bus.wr0_valid = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_valid = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.char_xy   = '0;   bus.clear_req = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        bus.wr0_valid = 1'b1;
        bus.wr1_valid = 1'b1;
        #2;
        check("rst_char_code",  32'(bus.char_code),  32'd0);
        check("rst_busy",       32'(bus.busy),       32'd1);
        check("rst_clear_done", 32'(bus.clear_done), 32'd0);
        check("rst_wr0_ready",  32'(bus.wr0_ready),  32'd0);
        check("rst_wr1_ready",  32'(bus.wr1_ready),  32'd0);
        bus.wr0_valid = 1'b0;
        bus.wr1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Edges 1..256 write cells 0..255; clear_done is high after edge 256,
        // i.e. it is captured by edge 257.
        wait_clear("rst", 256);

        read_cell(8'h00);
        read_cell(8'h7F);
        read_cell(8'hFF);

        // Both writers busy: grants alternate starting with writer 0.
        drive(1'b1, 8'h20, letter_code(5'd0), 1'b1, 8'h30, letter_code(5'd1), 1'b0, 8'h00, 1'b0, g);
        drive(1'b1, 8'h21, letter_code(5'd2), 1'b1, 8'h30, letter_code(5'd1), 1'b0, 8'h00, 1'b0, g);
        drive(1'b1, 8'h21, letter_code(5'd2), 1'b1, 8'h31, letter_code(5'd3), 1'b0, 8'h00, 1'b0, g);
        drive(1'b1, 8'h22, letter_code(5'd4), 1'b1, 8'h31, letter_code(5'd3), 1'b0, 8'h00, 1'b0, g);
        drive(1'b1, 8'h22, letter_code(5'd4), 1'b0, 8'h00, 7'h00,             1'b0, 8'h00, 1'b0, g);
        read_cell(8'h20);
        read_cell(8'h21);
        read_cell(8'h22);
        read_cell(8'h30);
        read_cell(8'h31);

        // Single writer, then read it back on the following cycle.
        drive(1'b1, 8'h05, ChG, 1'b0, 8'h00, 7'h00, 1'b0, 8'h00, 1'b0, g);
        read_cell(8'h05);

        // Read and write of the same cell in one cycle.
        drive(1'b1, 8'h10, ChM, 1'b0, 8'h00, 7'h00, 1'b1, 8'h10, 1'b0, g);
        read_cell(8'h10);

        // Random traffic: writers hold their request until granted.
        p0 = 1'b0; p1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int i = 0; i < 300; i++) begin
            if (!p0 && $urandom_range(0, 1) == 1) begin
                p0 = 1'b1; a0 = 8'($urandom); d0 = 7'($urandom);
            end
            if (!p1 && $urandom_range(0, 1) == 1) begin
                p1 = 1'b1; a1 = 8'($urandom); d1 = digit_code(4'($urandom_range(0, 9)));
            end
            drive(p0, a0, d0, p1, a1, d1, 1'b1, 8'($urandom), 1'b0, g);
            if (g == 0) p0 = 1'b0;
            if (g == 1) p1 = 1'b0;
        end
        idle_cycle();
        idle_cycle();

        // Clear request while writer 1 is requesting.
        drive(1'b0, 8'h00, 7'h00, 1'b1, 8'h40, letter_code(5'd7), 1'b0, 8'h00, 1'b1, g);
        @(negedge clk);
        check("clr_req_wr1_ready", 32'(bus.wr1_ready), 32'd0);
        check("clr_req_busy_low",  32'(bus.busy),      32'd0);
        // Sampling edge, then 256 writes, then DONE captured 258 edges on.
        wait_clear("req", 257);
        for (int i = 0; i < DEPTH; i++) read_cell(8'(i));
        idle_cycle();

        // Leave writer 0 as last winner, then reset in the middle of a clear.
        drive(1'b1, 8'h50, letter_code(5'd25), 1'b0, 8'h00, 7'h00, 1'b0, 8'h50, 1'b0, g);
        drive(1'b0, 8'h00, 7'h00, 1'b0, 8'h00, 7'h00, 1'b0, 8'h50, 1'b1, g);
        @(posedge clk);
        #1 bus.clear_req = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_char_code",  32'(bus.char_code),  32'd0);
        check("mid_rst_busy",       32'(bus.busy),       32'd1);
        check("mid_rst_clear_done", 32'(bus.clear_done), 32'd0);
        check("mid_rst_wr0_ready",  32'(bus.wr0_ready),  32'd0);
        m_last = 1;
        m_idle = 1'b0;
        gnt_q.delete();
        rd_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("rst_mid", 256);

        // Arbiter history restarts: writer 0 first again.
        drive(1'b1, 8'h60, letter_code(5'd15), 1'b1, 8'h61, letter_code(5'd16), 1'b0, 8'h00, 1'b0, g);
        drive(1'b0, 8'h00, 7'h00,              1'b1, 8'h61, letter_code(5'd16), 1'b0, 8'h00, 1'b0, g);
        read_cell(8'h60);
        read_cell(8'h61);
        read_cell(8'h50);
        idle_cycle();
        idle_cycle();

        check("gnt_q_drained", gnt_q.size(), 32'd0);
        check("rd_q_drained",  rd_q.size(),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/char_buf_ctrl.md
Name: char_buf_ctrl

Overview:
Writable 16x16 character buffer with its controller. It replaces the fixed text map between the VGA text-overlay pipeline and the font ROM. The display side reads char codes at 8-bit cell addresses {row[3:0], col[3:0]}. Two logic-side writers share the single write port through a round-robin arbiter, and a clear sequencer fills the whole buffer with a blank code after reset or on request.

Parameters:
ADDR_W, 8, cell address width (16 rows x 16 cols = 256 cells)
DATA_W, 7, char code width
CLEAR_CODE, vga_pkg::Spc, code written to every cell by the clear sequence

Ports:
clk  in  1  pixel-domain clock
rst_n  in  1  asynchronous active-low reset
char_xy  in  ADDR_W  display read address {row,col}
char_code  out  DATA_W  char code at char_xy, registered
wr0_valid  in  1  writer 0 (game logic) request
wr0_addr  in  ADDR_W  writer 0 cell address
wr0_data  in  DATA_W  writer 0 char code
wr0_ready  out  1  writer 0 accepted this cycle
wr1_valid  in  1  writer 1 (menu/status logic) request
wr1_addr  in  ADDR_W  writer 1 cell address
wr1_data  in  DATA_W  writer 1 char code
wr1_ready  out  1  writer 1 accepted this cycle
clear_req  in  1  single-cycle or level request to blank the buffer
busy  out  1  clear sequence in progress
clear_done  out  1  one-cycle pulse when a clear sequence finishes

Behaviour:
- Reset (rst_n low, async): char_code=0, wr0_ready=0, wr1_ready=0, clear_done=0, busy=1. State=ST_CLEAR, clear counter=0, arbiter last-grant=1 so writer 0 wins first. Buffer contents are not reset.
- Display read port is independent of the write side. char_code <= mem[char_xy] on every clk, 1-cycle latency.
- Read/write collision at the same address in the same cycle returns the old data (read-before-write).
- FSM ST_CLEAR:
  - Write mem[cnt]=CLEAR_CODE every cycle, cnt++. busy=1, both readies 0.
  - On the cycle cnt==255 is written, go to ST_DONE. The counter wraps to 0.
  - clear_req is ignored while in ST_CLEAR.
- FSM ST_DONE: one cycle. clear_done=1, busy=0, readies 0. Next state ST_IDLE.
- FSM ST_IDLE: busy=0.
  - If clear_req=1, both readies are forced 0 this cycle and the next state is ST_CLEAR with cnt=0.
  - Otherwise the arbiter runs.
- Arbiter (combinational ready, ST_IDLE only):
  - Only one valid: that writer gets ready=1.
  - Both valid: grant the writer not granted last.
  - On an accepted write (valid&&ready): mem[addr]<=data, last-grant<=granted index.
  - last-grant is unchanged when nothing is accepted.
  - At most one write per cycle.
- Writers hold valid/addr/data stable until ready. valid must not depend on ready.
- Full clear latency: 256 write cycles plus 1 DONE cycle.
  - After reset release, clear_done pulses on the 257th rising edge.
  - From clear_req sampled in IDLE, clear_done pulses 258 cycles later.
- Reset mid-clear restarts the clear from address 0.

Decomposition:
- vga_pkg gets a typedef enum logic [1:0] char_buf_state_t {ST_CLEAR, ST_DONE, ST_IDLE}, plus localparams CHAR_COLS=16, CHAR_ROWS=16. Char code constants (Spc, letters, digits) stay in vga_pkg.
- One sub-module, rr_arb2: 2-way round-robin arbiter with inputs req[1:0] and enable, output gnt[1:0], and internal last-grant register updated on an accept strobe.
- Buffer storage is a plain 256 x DATA_W array inside char_buf_ctrl, inferable as distributed/block RAM.

Test Plan:
- Reset release -> busy=1 for 256 cycles. clear_done=1 exactly on edge 257, then busy=0. Reading char_xy=8'h00, 8'h7F, 8'hFF gives Spc one cycle later.
- IDLE, wr0_valid=1 addr=8'h05 data=G for one cycle -> wr0_ready=1 same cycle. Reading char_xy=8'h05 returns G one cycle after the write edge.
- wr0_valid and wr1_valid held high for 4 cycles with distinct addr/data -> grants go writer 0,1,0,1. Each target cell holds its own data.
- Write 8'h10=M while reading char_xy=8'h10 in the same cycle -> char_code shows the old value (Spc). The next read shows M.
- clear_req pulsed while wr1_valid=1 -> wr1_ready=0 that cycle. busy rises next cycle, clear_done pulses 258 cycles after clear_req, and all 256 cells hold Spc.
- rst_n asserted at cnt=100 mid-clear -> outputs take reset values immediately. After release, a full 256-cycle clear from address 0 completes and clear_done pulses once.
